// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the memory port.
// The arbiter uses the slave modport; the requester/memory environment uses master.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        if_stall;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [2:0]  dm_size;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        dm_stall;

  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [2:0]  m_size;
  logic        m_ack;
  logic [31:0] m_rdata;

  logic        err;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_done, if_stall,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_size,
    output dm_rdata, dm_done, dm_stall,
    output m_req, m_we, m_addr, m_wdata, m_size,
    input  m_ack, m_rdata,
    output err
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_done, if_stall,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_size,
    input  dm_rdata, dm_done, dm_stall,
    input  m_req, m_we, m_addr, m_wdata, m_size,
    output m_ack, m_rdata,
    input  err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single memory port, one transaction
// outstanding, data-priority with fetch anti-starvation and a busy timeout.
//
// state   | meaning
// IDLE    | no transaction outstanding, arbitrate this cycle
// BUSY_IF | fetch command on the memory port, waiting for m_ack
// BUSY_DM | data command on the memory port, waiting for m_ack
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY_IF = 2'd1;
  localparam logic [1:0] BUSY_DM = 2'd2;

  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [TW-1:0] BUSY_LIM   = TW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] busy_cnt;

  logic          m_req_q;
  logic          m_we_q;
  logic [31:0]   m_addr_q;
  logic [31:0]   m_wdata_q;
  logic [2:0]    m_size_q;
  logic [31:0]   if_rdata_q;
  logic [31:0]   dm_rdata_q;
  logic          if_done_q;
  logic          dm_done_q;
  logic          err_q;

  logic          grant_dm;
  logic          grant_if;

  // Data wins unless the fetch side has already lost STARVE_MAX times in a row.
  assign grant_dm = bus.dm_req & (~bus.if_req | (starve_cnt != STARVE_LIM));
  assign grant_if = bus.if_req & ~grant_dm;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      busy_cnt   <= '0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_size_q   <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;
      err_q     <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_dm) begin
            state      <= BUSY_DM;
            m_req_q    <= 1'b1;
            m_we_q     <= bus.dm_we;
            m_addr_q   <= bus.dm_addr;
            m_wdata_q  <= bus.dm_wdata;
            m_size_q   <= bus.dm_size;
            busy_cnt   <= '0;
            // grant_dm with if_req set implies starve_cnt is below the limit
            starve_cnt <= bus.if_req ? starve_cnt + SW'(1) : '0;
          end else if (grant_if) begin
            state      <= BUSY_IF;
            m_req_q    <= 1'b1;
            m_we_q     <= 1'b0;
            m_addr_q   <= bus.if_addr;
            m_wdata_q  <= '0;
            m_size_q   <= 3'b010;
            busy_cnt   <= '0;
            starve_cnt <= '0;
          end else begin
            m_req_q <= 1'b0;
            if (!bus.if_req) starve_cnt <= '0;
          end
        end
        BUSY_IF, BUSY_DM: begin
          if (bus.m_ack) begin
            state   <= IDLE;
            m_req_q <= 1'b0;
            if (state == BUSY_IF) begin
              if_rdata_q <= bus.m_rdata;
              if_done_q  <= 1'b1;
            end else begin
              if (!m_we_q) dm_rdata_q <= bus.m_rdata;
              dm_done_q <= 1'b1;
            end
          end else if (busy_cnt == BUSY_LIM) begin
            state   <= IDLE;
            m_req_q <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            busy_cnt <= busy_cnt + TW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          m_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.m_req    = m_req_q;
  assign bus.m_we     = m_we_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_wdata  = m_wdata_q;
  assign bus.m_size   = m_size_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.dm_rdata = dm_rdata_q;
  assign bus.if_done  = if_done_q;
  assign bus.dm_done  = dm_done_q;
  assign bus.err      = err_q;

  assign bus.if_stall = bus.if_req & ~if_done_q;
  assign bus.dm_stall = bus.dm_req & ~dm_done_q;
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive data grants allowed while a fetch waits before fetch is forced.
REQ-002 Parameter TIMEOUT, default 255: busy cycles without M_ACK before the transaction is aborted.
REQ-003 CLK  in  1  sole clock, all state updates on rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 IF_REQ  in  1  instruction fetch request, held until IF_DONE.
REQ-006 IF_ADDR  in  32  fetch byte address.
REQ-007 IF_RDATA  out  32  fetched instruction word.
REQ-008 IF_DONE  out  1  one-cycle fetch completion pulse.
REQ-009 DM_REQ  in  1  data request, held until DM_DONE.
REQ-010 DM_WE  in  1  1 = store, 0 = load.
REQ-011 DM_ADDR  in  32  data byte address.
REQ-012 DM_WDATA  in  32  store data.
REQ-013 DM_SIZE  in  3  {sign, size[1:0]}, passed through.
REQ-014 DM_RDATA  out  32  load data.
REQ-015 DM_DONE  out  1  one-cycle data completion pulse.
REQ-016 IF_STALL / DM_STALL  out  1 each  requester must hold its pipeline stage.
REQ-017 M_REQ, M_WE  out  1 each; M_ADDR, M_WDATA  out  32 each; M_SIZE  out  3  registered memory-side command.
REQ-018 M_ACK  in  1  memory completion; M_RDATA  in  32  valid while M_ACK=1.
REQ-019 ERR  out  1  one-cycle pulse on timeout abort.

Function
REQ-020 FSM states IDLE, BUSY_IF, BUSY_DM; exactly one transaction outstanding at any time.
REQ-021 IDLE, no request: remain IDLE, M_REQ=0.
REQ-022 IDLE, only one request: grant it at the next edge (BUSY_IF or BUSY_DM).
REQ-023 IDLE, both requests: grant DM unless starve counter == STARVE_MAX, then grant IF.
REQ-024 Starve counter increments (saturating at STARVE_MAX) on each DM grant with IF_REQ=1; clears on any IF grant or when IF_REQ=0 in IDLE.
REQ-025 On grant, latch the granted requester's address, WE (0 for IF), WDATA (0 for IF) and SIZE (3'b010 for IF) into M_* regs; M_REQ=1 throughout BUSY_*.
REQ-026 BUSY_x with M_ACK=1: capture M_RDATA into x_RDATA, pulse x_DONE the following cycle, return to IDLE; M_REQ=0 that same following cycle.
REQ-027 Minimum latency: request sampled in IDLE at edge t, ack at t+1 -> DONE high during cycle after t+2 edge, i.e. 2 edges request-to-DONE; back-to-back grants allowed from IDLE re-entered with DONE.
REQ-028 x_RDATA holds its value until the next completion for x; stores leave DM_RDATA unchanged.
REQ-029 x_STALL = x_REQ & ~x_DONE, combinational.
REQ-030 Busy cycle counter clears on grant, increments each BUSY cycle; reaching TIMEOUT without M_ACK: return IDLE, pulse ERR, no DONE, M_REQ=0, requester remains stalled and re-arbitrates.
REQ-031 M_ACK while IDLE is ignored (no DONE, no RDATA update).
REQ-032 Request dropped by requester mid-transaction: transaction still completes; DONE still pulses.

Reset
REQ-033 RESET=1 at an edge: state IDLE, M_REQ=0, M_WE=0, M_ADDR/M_WDATA/M_SIZE=0, IF_DONE=DM_DONE=ERR=0, IF_RDATA=DM_RDATA=0, both counters 0; holds regardless of other inputs.
REQ-034 Reset mid-transaction abandons it; an ACK arriving after reset is ignored per REQ-031.

Verification
REQ-035 IF_REQ only, addr 0x100, M_ACK one cycle after M_REQ with M_RDATA=0x00000013 -> M_ADDR=0x100, IF_RDATA=0x13, IF_DONE single pulse, DM_DONE=0.
REQ-036 IF_REQ and DM_REQ both continuously high, immediate acks -> grant order DM,DM,DM,DM,IF,DM,... (STARVE_MAX=4).
REQ-037 DM store addr 0x2000 data 0xDEADBEEF size 3'b010 -> M_WE=1, M_WDATA=0xDEADBEEF, M_SIZE=3'b010, DM_DONE pulse, DM_RDATA unchanged.
REQ-038 DM load, M_ACK withheld for TIMEOUT cycles -> ERR single pulse, M_REQ drops, no DM_DONE, DM_STALL stays 1, re-grant next cycle.
REQ-039 RESET asserted while BUSY_IF, ACK arriving 2 cycles later -> outputs at reset values, IF_DONE never pulses.
REQ-040 Ack latency sweep 1..10 cycles on both ports -> exactly one DONE per grant, STALL deasserts only in the DONE cycle.
